adder_subtractor_4bit: RTL and testbench
========================================

# adder_subtractor_4bit

Registered 4-bit two's-complement adder/subtractor with one mode select, built as a ripple-carry chain of full-adder cells with conditional B inversion. It is the shared arithmetic primitive for small datapaths: it produces sum/difference, carry (or not-borrow), signed overflow and zero flags, and registers all results on one clock.

## Interface

- WIDTH, 4, operand and result width in bits; all requirements below are written for 4 and scale with WIDTH.
- One clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock for all result registers.
- rst  input  1  synchronous active-high reset.
- A  input  WIDTH  first operand (minuend in subtract mode).
- B  input  WIDTH  second operand (subtrahend in subtract mode).
- mode  input  1  0 = add (A+B), 1 = subtract (A−B).
- Sum  output  WIDTH  registered result, modulo 2^WIDTH.
- CarryOut  output  1  registered carry out of MSB cell; in subtract mode 1 = no borrow, 0 = borrow.
- Overflow  output  1  registered signed overflow (carry into MSB XOR carry out of MSB).
- Zero  output  1  registered, 1 when Sum == 0.

## Operation

- Effective operand: Bx = B XOR {WIDTH{mode}}; carry-in to LSB cell c0 = mode.
- Chain: cell i computes s_i = A_i ^ Bx_i ^ c_i, c_{i+1} = A_i&Bx_i | c_i&(A_i^Bx_i); i = 0..WIDTH−1, ripple order LSB→MSB.
- Unregistered result {c_WIDTH, s} = A + Bx + mode (WIDTH+1 bits); Sum = s, CarryOut = c_WIDTH.
- Overflow = c_WIDTH ^ c_{WIDTH−1}; meaningful for signed interpretation only, always computed.
- Zero = (s == 0); derived from the combinational sum, registered alongside it.
- Add mode: CarryOut = 1 exactly when unsigned A+B ≥ 2^WIDTH.
- Subtract mode: CarryOut = 1 exactly when unsigned A ≥ B; A == B gives Sum 0, CarryOut 1, Zero 1.
- Mode switches are fully combinational before the register; no state carried between operations.
- No X-propagation handling beyond standard RTL semantics; inputs are assumed driven every cycle.

## Timing

- All outputs registered on rising clk; latency exactly 1 cycle: inputs present before edge N appear on outputs after edge N.
- New operands accepted every cycle; throughput 1 result/cycle; no handshake.
- rst sampled at rising edge, highest priority: on that edge Sum=0, CarryOut=0, Overflow=0, Zero=1, regardless of A/B/mode.
- Reset mid-stream: the operation sampled on the reset edge is discarded; first valid result appears on the edge after rst deasserts.
- Before the first clock edge outputs are undefined; benches must apply rst for ≥1 cycle.
- Combinational path: WIDTH ripple stages plus one XOR and the zero-detect; must close at target clock with no multicycle constraint.

## Test plan

- Reset: rst=1 for 2 cycles with A=4'b1111, B=4'b0001, mode=0 -> Sum=0000, CarryOut=0, Overflow=0, Zero=1; after release next edge gives Sum=0000, CarryOut=1, Zero=1.
- Addition: A=0001,B=0010,mode=0 -> Sum=0011, CarryOut=0; A=1010,B=0101,mode=0 -> Sum=1111, CarryOut=0, Overflow=0 (one cycle after each apply).
- Add carry/overflow: A=1111,B=0001,mode=0 -> Sum=0000, CarryOut=1, Zero=1, Overflow=0; A=0111,B=0001,mode=0 -> Sum=1000, CarryOut=0, Overflow=1.
- Subtraction: A=1001,B=0011,mode=1 -> Sum=0110, CarryOut=1; A=0000,B=0000,mode=1 -> Sum=0000, CarryOut=1, Zero=1.
- Borrow: A=0100,B=1000,mode=1 -> Sum=1100, CarryOut=0, Overflow=1 (4 − (−8) overflows signed).
- Back-to-back throughput: change operands and mode every cycle across all 512 combinations -> each output matches {CarryOut,Sum} = A + (B^{4{mode}}) + mode from the previous cycle, with Overflow/Zero consistent.

Source files
------------

// File: rtl/adder_subtractor_4bit.sv
// Registered ripple-carry adder/subtractor with carry, overflow and zero flags.
// mode=1 inverts B and injects a carry-in, giving A - B in two's complement.
module adder_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut,
    output logic             Overflow,
    output logic             Zero
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH:0]   c;
    logic             carry_d;
    logic             ovf_d;
    logic             zero_d;

    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;

    always_comb begin
        bx    = B ^ {WIDTH{mode}};
        sum_d = '0;
        c     = '0;
        c[0]  = mode;
        // Full-adder cells, rippling LSB to MSB
        for (int i = 0; i < WIDTH; i++) begin
            sum_d[i] = A[i] ^ bx[i] ^ c[i];
            c[i+1]   = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
        end
        carry_d = c[WIDTH];
        ovf_d   = c[WIDTH] ^ c[WIDTH-1];
        zero_d  = (sum_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign Sum      = sum_q;
    assign CarryOut = carry_q;
    assign Overflow = ovf_q;
    assign Zero     = zero_q;

endmodule

// File: tb/tb_adder_subtractor_4bit.sv
// Directed and exhaustive checks for the registered 4-bit adder/subtractor.
// Results are compared as {Overflow, Zero, CarryOut, Sum}.
module tb_adder_subtractor_4bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic       mode;
    logic [3:0] Sum;
    logic       CarryOut;
    logic       Overflow;
    logic       Zero;

    int checks;
    int failures;

    adder_subtractor_4bit #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .mode     (mode),
        .Sum      (Sum),
        .CarryOut (CarryOut),
        .Overflow (Overflow),
        .Zero     (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] pack(input logic ovf, input logic z,
                                        input logic co, input logic [3:0] s);
        return {ovf, z, co, s};
    endfunction

    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {Overflow, Zero, CarryOut, Sum};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply operands, clock once, then check the registered result
    task automatic step(input string tag, input logic [3:0] a,
                        input logic [3:0] b, input logic m,
                        input logic [6:0] exp);
        A = a;
        B = b;
        mode = m;
        @(posedge clk);
        #1;
        chk(tag, exp);
    endtask

    initial begin
        logic [3:0] bx;
        logic [4:0] full;
        logic       ovf;
        checks   = 0;
        failures = 0;

        rst  = 1'b1;
        A    = 4'b1111;
        B    = 4'b0001;
        mode = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("reset_1", pack(1'b0, 1'b1, 1'b0, 4'b0000));
        @(posedge clk);
        #1;
        chk("reset_2", pack(1'b0, 1'b1, 1'b0, 4'b0000));

        rst = 1'b0;
        step("post_reset", 4'b1111, 4'b0001, 1'b0,
             pack(1'b0, 1'b1, 1'b1, 4'b0000));

        step("add_1_2", 4'b0001, 4'b0010, 1'b0,
             pack(1'b0, 1'b0, 1'b0, 4'b0011));
        step("add_a_5", 4'b1010, 4'b0101, 1'b0,
             pack(1'b0, 1'b0, 1'b0, 4'b1111));
        step("add_carry", 4'b1111, 4'b0001, 1'b0,
             pack(1'b0, 1'b1, 1'b1, 4'b0000));
        step("add_ovf", 4'b0111, 4'b0001, 1'b0,
             pack(1'b1, 1'b0, 1'b0, 4'b1000));
        step("sub_9_3", 4'b1001, 4'b0011, 1'b1,
             pack(1'b1, 1'b0, 1'b1, 4'b0110));
        step("sub_0_0", 4'b0000, 4'b0000, 1'b1,
             pack(1'b0, 1'b1, 1'b1, 4'b0000));
        step("sub_borrow", 4'b0100, 4'b1000, 1'b1,
             pack(1'b1, 1'b0, 1'b0, 4'b1100));
        step("sub_eq", 4'b0110, 4'b0110, 1'b1,
             pack(1'b0, 1'b1, 1'b1, 4'b0000));
        step("sub_small", 4'b0011, 4'b0101, 1'b1,
             pack(1'b0, 1'b0, 1'b0, 4'b1110));

        rst = 1'b1;
        step("midreset", 4'b0111, 4'b0111, 1'b0,
             pack(1'b0, 1'b1, 1'b0, 4'b0000));
        rst = 1'b0;
        step("after_mid", 4'b0010, 4'b0011, 1'b0,
             pack(1'b0, 1'b0, 1'b0, 4'b0101));

        // Every operand/mode combination, one new operation per cycle
        for (int i = 0; i < 512; i++) begin
            A    = i[3:0];
            B    = i[7:4];
            mode = i[8];
            bx   = B ^ {4{mode}};
            full = {1'b0, A} + {1'b0, bx} + {4'b0, mode};
            ovf  = (A[3] == bx[3]) && (full[3] != A[3]);
            @(posedge clk);
            #1;
            chk($sformatf("sweep_%0d", i),
                pack(ovf, full[3:0] == 4'b0, full[4], full[3:0]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
